// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply and divide units.
//   MD_WIDTH     : operand width of the multiply/divide datapath
//   md_state_e   : handshake FSM states shared by both units
//   booth_op_e   : radix-4 Booth recode operations
//   booth_recode : maps a {Q[1], Q[0], q_m1} triplet to its Booth operation
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md_state_e;

    typedef enum logic [2:0] {
        BOOTH_ZERO,
        BOOTH_P1,
        BOOTH_P2,
        BOOTH_M1,
        BOOTH_M2
    } booth_op_e;

    function automatic booth_op_e booth_recode(input logic [2:0] trip);
        booth_op_e op;
        case (trip)
            3'b001, 3'b010: op = BOOTH_P1;
            3'b011:         op = BOOTH_P2;
            3'b100:         op = BOOTH_M2;
            3'b101, 3'b110: op = BOOTH_M1;
            default:        op = BOOTH_ZERO;  // 000 and 111
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-4 Booth iteration.
//   a_cur, q_cur, q_m1_cur : current accumulator, multiplier and guard bit
//   m                      : multiplicand, sign-extended to WIDTH+2
//   a_nxt, q_nxt, q_m1_nxt : {A,Q,q_m1} after add and 2-bit arithmetic shift
module booth_step
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH+1:0] a_cur,
    input  logic [WIDTH-1:0] q_cur,
    input  logic             q_m1_cur,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] a_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    booth_op_e        op;
    logic [WIDTH+1:0] term;
    logic             sub;
    logic [WIDTH+1:0] operand;
    logic [WIDTH+1:0] sum;

    assign op = booth_recode({q_cur[1:0], q_m1_cur});

    always_comb begin
        term = '0;
        sub  = 1'b0;
        unique case (op)
            BOOTH_P1: term = m;
            BOOTH_P2: term = {m[WIDTH:0], 1'b0};
            BOOTH_M1: begin
                term = m;
                sub  = 1'b1;
            end
            BOOTH_M2: begin
                term = {m[WIDTH:0], 1'b0};
                sub  = 1'b1;
            end
            default:  term = '0;
        endcase
    end

    // Subtraction is ~term with the +1 supplied through the carry-in.
    assign operand = sub ? ~term : term;

    generate
        if (WIDTH == 32) begin : g_cla
            logic [31:0] lo;
            logic        carry;
            logic [1:0]  hi;

            cla_32 u_cla (
                .a   (a_cur[31:0]),
                .b   (operand[31:0]),
                .cin (sub),
                .sum (lo),
                .cout(carry)
            );

            // Two guard bits keep -2M of the most negative operand in range.
            assign hi  = a_cur[WIDTH+1:WIDTH] + operand[WIDTH+1:WIDTH] + {1'b0, carry};
            assign sum = {hi, lo};
        end else begin : g_add
            assign sum = a_cur + operand + {{(WIDTH + 1){1'b0}}, sub};
        end
    endgenerate

    assign a_nxt    = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    assign q_nxt    = {sum[1:0], q_cur[WIDTH-1:2]};
    assign q_m1_nxt = q_cur[1];

endmodule

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with the group
// carries chained between groups.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 32 bits
//   cout : carry out of bit 31
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_grp
            logic       c_in;
            logic [3:0] p;
            logic [3:0] g;
            logic [4:0] c;

            if (gi == 0) begin : g_first
                assign c_in = cin;
            end else begin : g_chain
                assign c_in = g_grp[gi-1].c[4];
            end

            assign p = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign g = a[4*gi +: 4] & b[4*gi +: 4];

            assign c[0] = c_in;
            assign c[1] = g[0] | (p[0] & c_in);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c_in);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c_in);

            assign sum[4*gi +: 4] = p ^ c[3:0];
        end
    endgenerate

    assign cout = g_grp[7].c[4];

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   ctrl_MULT      : start pulse; operands sampled in the same cycle
//   data_operandA  : multiplicand (two's complement)
//   data_operandB  : multiplier (two's complement)
//   data_result    : low WIDTH bits of the product (held)
//   data_product   : full 2*WIDTH signed product (held)
//   data_exception : product does not fit in WIDTH signed bits (held)
//   data_resultRDY : one-cycle pulse when the outputs are fresh
//   busy           : high while an operation is in RUN or DONE
module mult_booth_seq
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned ITERS = WIDTH / 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_MULT,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic [WIDTH-1:0]   data_result,
    output logic [2*WIDTH-1:0] data_product,
    output logic               data_exception,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LastCount = CW'(ITERS - 1);

    md_state_e state_q, state_d;

    logic [CW-1:0]      counter_q;
    logic [WIDTH+1:0]   m_q;
    logic [WIDTH+1:0]   a_q;
    logic [WIDTH-1:0]   q_q;
    logic               q_m1_q;
    logic [WIDTH-1:0]   result_q;
    logic [2*WIDTH-1:0] product_q;
    logic               exception_q;

    logic [WIDTH+1:0]   a_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               q_m1_nxt;
    logic [2*WIDTH-1:0] product_nxt;
    logic [WIDTH:0]     top_bits;
    logic               exception_nxt;
    logic               last_iter;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a_cur   (a_q),
        .q_cur   (q_q),
        .q_m1_cur(q_m1_q),
        .m       (m_q),
        .a_nxt   (a_nxt),
        .q_nxt   (q_nxt),
        .q_m1_nxt(q_m1_nxt)
    );

    // The output registers are loaded on the final iteration so they are
    // already valid in the DONE (RDY) cycle.
    assign product_nxt   = {a_nxt[WIDTH-1:0], q_nxt};
    assign top_bits      = product_nxt[2*WIDTH-1:WIDTH-1];
    assign exception_nxt = ~((&top_bits) | ~(|top_bits));
    assign last_iter     = (counter_q == LastCount);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl_MULT) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                busy           = 1'b1;
                data_resultRDY = 1'b1;
                // A start in the RDY cycle chains straight into the next run.
                state_d        = ctrl_MULT ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q   <= '0;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            q_m1_q      <= 1'b0;
            result_q    <= '0;
            product_q   <= '0;
            exception_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        m_q       <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                        a_q       <= '0;
                        q_q       <= data_operandB;
                        q_m1_q    <= 1'b0;
                        counter_q <= '0;
                    end
                end
                RUN: begin
                    a_q       <= a_nxt;
                    q_q       <= q_nxt;
                    q_m1_q    <= q_m1_nxt;
                    counter_q <= counter_q + 1'b1;
                    if (last_iter) begin
                        result_q    <= q_nxt;
                        product_q   <= product_nxt;
                        exception_q <= exception_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_product   = product_q;
    assign data_exception = exception_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
module tb_mult_booth_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [63:0] data_product;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    mult_booth_seq dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_product  (data_product),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic.
    function automatic longint ref_product(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic ref_exception(input longint p);
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    // Start one multiply, wait (bounded) for RDY, check latency, results and hold.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
        longint exp_p;
        int     lat;
        logic [63:0] got_p;
        exp_p = ref_product(a, b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 1;
        check({tag, ".busy"}, {63'd0, busy}, 64'd1);
        while (!data_resultRDY && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd17);
        check({tag, ".product"}, data_product, exp_p);
        check({tag, ".result"}, {32'd0, data_result}, {32'd0, exp_p[31:0]});
        check({tag, ".exc"}, {63'd0, data_exception}, {63'd0, ref_exception(exp_p)});
        got_p = data_product;
        @(negedge clock);
        check({tag, ".pulse"}, {63'd0, data_resultRDY}, 64'd0);
        check({tag, ".hold"}, data_product, got_p);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("rst.result", {32'd0, data_result}, 64'd0);
        check("rst.product", data_product, 64'd0);
        check("rst.exc", {63'd0, data_exception}, 64'd0);
        check("rst.rdy", {63'd0, data_resultRDY}, 64'd0);
        check("rst.busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;

        // Directed operands from the test plan plus edge cases.
        do_mult(32'd7, 32'd6, "7x6");
        check("7x6.const", data_product, 64'h0000_0000_0000_002A);
        do_mult(32'hFFFF_FFFD, 32'd5, "m3x5");
        check("m3x5.const", data_product, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, "minxm1");
        check("minxm1.const", data_product, 64'h0000_0000_8000_0000);
        do_mult(32'h0001_0000, 32'h0001_0000, "2p16sq");
        check("2p16sq.const", data_product, 64'h0000_0001_0000_0000);
        do_mult(32'h8000_0000, 32'h8000_0000, "minsq");
        check("minsq.const", data_product, 64'h4000_0000_0000_0000);
        do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxsq");
        do_mult(32'h8000_0000, 32'h7FFF_FFFF, "minxmax");
        do_mult(32'h0000_0000, 32'h1234_5678, "zeroa");
        do_mult(32'h8765_4321, 32'h0000_0000, "zerob");
        do_mult(32'h0000_FFFF, 32'hFFFF_0001, "mixed");

        for (int i = 0; i < 16; i++) begin
            do_mult($urandom, $urandom, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            do_mult($urandom_range(0, 65535), 32'(-$urandom_range(1, 65535)),
                    $sformatf("rsmall%0d", i));
        end

        // Handshake: start ignored in RUN, accepted in DONE.
        @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 1) ctrl_MULT = 1'b0;
            check($sformatf("hs1.busy%0d", k), {63'd0, busy}, 64'd1);
            check($sformatf("hs1.rdy%0d", k), {63'd0, data_resultRDY}, {63'd0, k == 17});
            if (k == 5) begin
                data_operandA = 32'd2;
                data_operandB = 32'd3;
                ctrl_MULT     = 1'b1;
            end
            if (k == 6) ctrl_MULT = 1'b0;
        end
        check("hs1.product", data_product, 64'd81);
        check("hs1.result", {32'd0, data_result}, 64'd81);
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        ctrl_MULT     = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 1) ctrl_MULT = 1'b0;
            check($sformatf("hs2.busy%0d", k), {63'd0, busy}, 64'd1);
            check($sformatf("hs2.rdy%0d", k), {63'd0, data_resultRDY}, {63'd0, k == 17});
        end
        check("hs2.product", data_product, 64'd6);
        check("hs2.result", {32'd0, data_result}, 64'd6);
        @(negedge clock);
        check("hs2.idle", {63'd0, busy}, 64'd0);

        // Reset after five iterations aborts the operation.
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h9ABC_DEF0;
        ctrl_MULT     = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) ctrl_MULT = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.product", data_product, 64'd0);
        check("abort.result", {32'd0, data_result}, 64'd0);
        check("abort.exc", {63'd0, data_exception}, 64'd0);
        check("abort.rdy", {63'd0, data_resultRDY}, 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check($sformatf("abort.nordy%0d", k), {63'd0, data_resultRDY | busy}, 64'd0);
        end
        do_mult(32'd1, 32'hFFFF_FFFF, "1xm1");
        check("1xm1.const", data_product, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        check("rstwin.busy", {63'd0, busy}, 64'd0);
        check("rstwin.product", data_product, 64'd0);
        @(negedge clock);
        check("rstwin.busy2", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
